// File: rtl/move_detector.sv
// Turns debounced board occupancy scans into chess move events (plain moves and captures)
// and presents them over a valid/ready handshake.
module move_detector #(
  parameter int STABLE_SCANS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] layout,
  input  logic        layout_valid,
  input  logic        move_ready,
  output logic        move_valid,
  output logic [5:0]  move_from,
  output logic [5:0]  move_to,
  output logic        move_capture,
  output logic [63:0] board,
  output logic        error
);

  // state | meaning
  // INIT  | waiting for the first stable layout to load as the board
  // IDLE  | board matches pieces at rest
  // LIFT1 | one piece lifted (square fa)
  // LIFT2 | two pieces lifted (fa first, then fb)
  // EMIT  | move presented, waiting for move_ready
  typedef enum logic [2:0] {INIT, IDLE, LIFT1, LIFT2, EMIT} state_t;

  localparam int CW = $clog2(STABLE_SCANS + 1);
  localparam logic [CW-1:0] SAT = CW'(STABLE_SCANS);
  localparam logic [CW-1:0] ONE = CW'(1);

  logic [63:0] cand, stable;
  logic [CW-1:0] cnt, cnt_nxt;
  logic stable_new, fire, clear_new;

  state_t state, state_n;
  logic [63:0] board_n;
  logic [5:0] fa, fb, fa_n, fb_n, from_n, to_n;
  logic cap_n, err_n;

  logic [63:0] rem, add;
  logic one_rem, one_add;
  logic [5:0] idx;

  function automatic logic [5:0] low_idx(input logic [63:0] v);
    logic [5:0] r;
    r = '0;
    for (int i = 63; i >= 0; i--) begin
      if (v[i]) r = 6'(i);
    end
    return r;
  endfunction

  // A layout differing from the candidate restarts the count, so with
  // STABLE_SCANS=1 each changed layout fires on its first scan.
  always_comb begin
    cnt_nxt = cnt;
    fire = 1'b0;
    if (layout_valid) begin
      if (layout != cand) cnt_nxt = ONE;
      else if (cnt != SAT) cnt_nxt = cnt + ONE;
      fire = (cnt_nxt == SAT) && ((layout != cand) || (cnt != SAT));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cand <= '0;
      cnt <= '0;
      stable <= '0;
      stable_new <= 1'b0;
    end else begin
      if (layout_valid) begin
        cand <= layout;
        cnt <= cnt_nxt;
      end
      if (fire) begin
        stable <= layout;
        stable_new <= 1'b1;
      end else if (clear_new) begin
        stable_new <= 1'b0;
      end
    end
  end

  assign rem = board & ~stable;
  assign add = stable & ~board;
  assign one_rem = (rem != '0) && ((rem & (rem - 64'd1)) == '0) && (add == '0);
  assign one_add = (add != '0) && ((add & (add - 64'd1)) == '0) && (rem == '0);
  assign idx = one_rem ? low_idx(rem) : low_idx(add);

  always_comb begin
    state_n = state;
    board_n = board;
    fa_n = fa;
    fb_n = fb;
    from_n = move_from;
    to_n = move_to;
    cap_n = move_capture;
    err_n = 1'b0;
    clear_new = 1'b0;
    case (state)
      INIT: begin
        if (stable_new) begin
          clear_new = 1'b1;
          board_n = stable;
          state_n = IDLE;
        end
      end
      IDLE: begin
        if (stable_new) begin
          clear_new = 1'b1;
          if (stable != board) begin
            board_n = stable;
            if (one_rem) begin
              fa_n = idx;
              state_n = LIFT1;
            end else begin
              err_n = 1'b1;
            end
          end
        end
      end
      LIFT1: begin
        if (stable_new) begin
          clear_new = 1'b1;
          if (stable != board) begin
            board_n = stable;
            if (one_add && idx == fa) begin
              state_n = IDLE;
            end else if (one_add) begin
              from_n = fa;
              to_n = idx;
              cap_n = 1'b0;
              state_n = EMIT;
            end else if (one_rem) begin
              fb_n = idx;
              state_n = LIFT2;
            end else begin
              err_n = 1'b1;
              state_n = IDLE;
            end
          end
        end
      end
      LIFT2: begin
        if (stable_new) begin
          clear_new = 1'b1;
          if (stable != board) begin
            board_n = stable;
            state_n = EMIT;
            cap_n = 1'b1;
            if (one_add && idx == fa) begin
              from_n = fb;
              to_n = fa;
            end else if (one_add && idx == fb) begin
              from_n = fa;
              to_n = fb;
            end else begin
              cap_n = move_capture;
              err_n = 1'b1;
              state_n = IDLE;
            end
          end
        end
      end
      EMIT: begin
        if (move_ready) state_n = IDLE;
      end
      default: state_n = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= INIT;
      board <= '0;
      fa <= '0;
      fb <= '0;
      move_from <= '0;
      move_to <= '0;
      move_capture <= 1'b0;
      error <= 1'b0;
    end else begin
      state <= state_n;
      board <= board_n;
      fa <= fa_n;
      fb <= fb_n;
      move_from <= from_n;
      move_to <= to_n;
      move_capture <= cap_n;
      error <= err_n;
    end
  end

  assign move_valid = (state == EMIT);

endmodule

// File: tb/tb_move_detector.sv
// Directed bench for move_detector: expected moves are queued when stimulus is
// driven and compared when the DUT presents them.
module tb_move_detector;
  logic clk, reset, layout_valid, move_ready;
  logic [63:0] layout;
  logic move_valid, move_capture, error;
  logic [5:0] move_from, move_to;
  logic [63:0] board;

  int errors = 0;
  int checks = 0;
  int err_seen = 0;
  int acc_seen = 0;
  logic [12:0] sb[$];

  localparam logic [63:0] INIT_B = 64'hFFFF00000000FFFF;

  move_detector dut (
    .clk(clk), .reset(reset), .layout(layout), .layout_valid(layout_valid),
    .move_ready(move_ready), .move_valid(move_valid), .move_from(move_from),
    .move_to(move_to), .move_capture(move_capture), .board(board), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset) begin
      if (error) err_seen++;
      if (move_valid && move_ready) acc_seen++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic scans(input logic [63:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      layout = v;
      layout_valid = 1'b1;
      @(posedge clk); #1;
      layout_valid = 1'b0;
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_valid"}, move_valid, 1'b0);
    chk({tag, "_fields"}, {move_from, move_to, move_capture}, 13'd0);
    chk({tag, "_board"}, board, 64'd0);
    chk({tag, "_error"}, error, 1'b0);
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!move_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_timeout"}, move_valid, 1'b1);
  endtask

  task automatic pop_move(input string tag);
    logic [12:0] exp;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=move expected=empty_queue", tag);
    end else begin
      exp = sb.pop_front();
      chk(tag, {move_from, move_to, move_capture}, exp);
    end
  endtask

  logic [63:0] b1, b2, c0, c1, c2, c3, d1, d2, d3, d4, d5;

  initial begin
    reset = 1'b1;
    layout = '0;
    layout_valid = 1'b0;
    move_ready = 1'b0;
    cycles(2);
    check_zero("reset");
    reset = 1'b0;

    // initial load
    scans(INIT_B, 4);
    cycles(2);
    chk("init_board", board, INIT_B);
    chk("init_events", {32'(err_seen), 32'(acc_seen)}, 64'd0);
    chk("init_valid", move_valid, 1'b0);

    // plain move 12 -> 28 with held ready
    b1 = INIT_B & ~(64'd1 << 12);
    b2 = b1 | (64'd1 << 28);
    scans(b1, 4);
    cycles(2);
    chk("lift_board", board, b1);
    sb.push_back({6'd12, 6'd28, 1'b0});
    scans(b2, 4);
    chk("plain_early", move_valid, 1'b0);
    @(posedge clk); #1;
    chk("plain_latency", move_valid, 1'b1);
    pop_move("plain_fields");
    for (int i = 0; i < 10; i++) begin
      chk("plain_hold", {move_valid, move_from, move_to, move_capture}, {1'b1, 6'd12, 6'd28, 1'b0});
      @(posedge clk); #1;
    end
    move_ready = 1'b1;
    @(posedge clk); #1;
    chk("plain_drop", move_valid, 1'b0);
    chk("plain_board", board, b2);

    // bounce
    for (int i = 0; i < 20; i++) scans((i % 2 == 0) ? (b2 | (64'd1 << 12)) : b2, 1);
    cycles(3);
    chk("bounce_board", board, b2);
    chk("bounce_events", {32'(err_seen), 32'(acc_seen)}, {32'd0, 32'd1});

    // capture: 28 takes 35
    do_reset();
    reset = 1'b0;
    c0 = INIT_B | (64'd1 << 28) | (64'd1 << 35);
    c1 = c0 & ~(64'd1 << 35);
    c2 = c1 & ~(64'd1 << 28);
    c3 = c2 | (64'd1 << 35);
    scans(c0, 4);
    cycles(2);
    chk("cap_load", board, c0);
    scans(c1, 4);
    scans(c2, 4);
    sb.push_back({6'd28, 6'd35, 1'b1});
    scans(c3, 4);
    @(posedge clk); #1;
    chk("cap_valid", move_valid, 1'b1);
    pop_move("cap_fields");
    chk("cap_board", {board[28], board[35]}, 2'b01);
    @(posedge clk); #1;
    chk("cap_drop", move_valid, 1'b0);

    // replace then double-lift error
    d1 = c3 & ~(64'd1 << 12);
    d2 = c3 & ~(64'd3 << 12);
    scans(d1, 4);
    scans(c3, 4);
    cycles(3);
    chk("replace_board", board, c3);
    chk("replace_events", {32'(err_seen), 32'(acc_seen)}, {32'd0, 32'd2});
    scans(d2, 4);
    chk("err_early", error, 1'b0);
    @(posedge clk); #1;
    chk("err_pulse", error, 1'b1);
    chk("err_board", board, d2);
    @(posedge clk); #1;
    chk("err_width", error, 1'b0);

    // reset in LIFT1
    d3 = d2 & ~(64'd1 << 14);
    scans(d3, 4);
    cycles(2);
    chk("l1_board", board, d3);
    do_reset();
    check_zero("rst_lift1");
    reset = 1'b0;
    scans(d3, 4);
    cycles(3);
    chk("rst_lift1_reload", board, d3);
    chk("rst_lift1_valid", move_valid, 1'b0);

    // reset in EMIT with ready low
    move_ready = 1'b0;
    d4 = d3 & ~(64'd1 << 15);
    d5 = d4 | (64'd1 << 23);
    scans(d4, 4);
    sb.push_back({6'd15, 6'd23, 1'b0});
    scans(d5, 4);
    wait_valid("emit_wait");
    pop_move("emit_fields");
    do_reset();
    check_zero("rst_emit");
    reset = 1'b0;
    scans(d5, 4);
    cycles(3);
    chk("rst_emit_reload", board, d5);
    chk("final_events", {32'(err_seen), 32'(acc_seen)}, {32'd1, 32'd2});
    chk("final_queue", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
